// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/grant/response data port, byte-lane alignment, stall and bus-timeout.
// Optional misaligned-access exceptions are enabled by defining MEM_MISALIGN_EXC_EN.
module mem_lsu #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              EX_valid,
   input  logic              EX_Mem_wr_en,
   input  logic              EX_Mem_rd_en,
   input  logic [2:0]        EX_Mem_op,
   input  logic              EX_MemToReg,
   input  logic              EX_RegFile_wr_en,
   input  logic              EX_Exception,
   input  logic [31:0]       EX_ALU_result,
   input  logic [31:0]       EX_Rs2_data,
   input  logic [4:0]        EX_Rd_addr,
   output logic              MEM_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rd_data,
   output logic              MEM_valid,
   output logic              MEM_MemToReg,
   output logic              MEM_RegFile_wr_en,
   output logic              MEM_Exception,
   output logic [1:0]        MEM_exc_cause,
   output logic [31:0]       MEM_ALU_result,
   output logic [31:0]       MEM_dout,
   output logic [4:0]        MEM_Rd_addr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RSP  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             is_half;
   logic             is_word;
   logic [1:0]       a;
   logic [1:0]       a_eff;
   logic             misaligned;
   logic             memop;
   logic             done;
   logic             timeout;
   logic [31:0]      rd_shift;
   logic [31:0]      load_data;

   assign a       = EX_ALU_result[1:0];
   assign is_half = (EX_Mem_op[1:0] == 2'b01);
   assign is_word = (EX_Mem_op[1:0] == 2'b10);
   assign a_eff   = is_word ? 2'b00 : (is_half ? {a[1], 1'b0} : a);

`ifdef MEM_MISALIGN_EXC_EN
   assign misaligned = EX_valid & (EX_Mem_rd_en | EX_Mem_wr_en) & ~EX_Exception &
                       ((is_half & a[0]) | (is_word & (a != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   assign memop     = EX_valid & (EX_Mem_rd_en | EX_Mem_wr_en) & ~EX_Exception & ~misaligned;
   assign MEM_stall = memop & ~done;
   assign mem_we    = EX_Mem_wr_en;
   assign mem_addr  = {EX_ALU_result[ADDR_W-1:2], 2'b00};

   always_comb begin
      mem_be      = 4'b1111;
      mem_wr_data = EX_Rs2_data;
      case (EX_Mem_op[1:0])
         2'b00: begin
            mem_be      = 4'b0001 << a_eff;
            mem_wr_data = {4{EX_Rs2_data[7:0]}};
         end
         2'b01: begin
            mem_be      = 4'b0011 << a_eff;
            mem_wr_data = {2{EX_Rs2_data[15:0]}};
         end
         default: begin
            mem_be      = 4'b1111;
            mem_wr_data = EX_Rs2_data;
         end
      endcase
   end

   assign rd_shift = mem_rd_data >> {a_eff, 3'b000};

   always_comb begin
      load_data = rd_shift;
      case (EX_Mem_op)
         3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  load_data = {24'h000000, rd_shift[7:0]};
         3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b101:  load_data = {16'h0000, rd_shift[15:0]};
         default: load_data = rd_shift;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            cnt <= '0;
         else if (!mem_rvalid)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Responses seen in IDLE (including one alongside the grant) are never consumed.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      timeout   = 1'b0;
      mem_req   = 1'b0;
      case (state)
         IDLE: begin
            mem_req = memop & Reset_n;
            if (memop && mem_gnt) begin
               if (EX_Mem_wr_en)
                  done = 1'b1;
               else
                  state_nxt = RSP;
            end
         end
         RSP: begin
            if (mem_rvalid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               done      = 1'b1;
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         MEM_valid         <= 1'b0;
         MEM_MemToReg      <= 1'b0;
         MEM_RegFile_wr_en <= 1'b0;
         MEM_Exception     <= 1'b0;
         MEM_exc_cause     <= 2'b00;
         MEM_ALU_result    <= 32'h0;
         MEM_dout          <= 32'h0;
         MEM_Rd_addr       <= 5'h0;
      end else if (!MEM_stall) begin
         MEM_valid         <= EX_valid;
         MEM_MemToReg      <= EX_MemToReg;
         MEM_RegFile_wr_en <= EX_RegFile_wr_en & ~timeout & ~misaligned;
         MEM_Exception     <= EX_Exception | timeout | misaligned;
         MEM_exc_cause     <= timeout ? 2'b11 :
                              (misaligned ? (EX_Mem_rd_en ? 2'b01 : 2'b10) : 2'b00);
         MEM_ALU_result    <= EX_ALU_result;
         MEM_Rd_addr       <= EX_Rd_addr;
         if (state == RSP && mem_rvalid)
            MEM_dout <= load_data;
      end else begin
         MEM_valid         <= 1'b0;
         MEM_MemToReg      <= 1'b0;
         MEM_RegFile_wr_en <= 1'b0;
         MEM_Exception     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu; expectations switch on MEM_MISALIGN_EXC_EN where behaviour differs.
module tb_mem_lsu;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;

   logic        Clk;
   logic        Reset_n;
   logic        EX_valid, EX_Mem_wr_en, EX_Mem_rd_en;
   logic [2:0]  EX_Mem_op;
   logic        EX_MemToReg, EX_RegFile_wr_en, EX_Exception;
   logic [31:0] EX_ALU_result, EX_Rs2_data;
   logic [4:0]  EX_Rd_addr;
   logic        MEM_stall, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wr_data;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rd_data;
   logic        MEM_valid, MEM_MemToReg, MEM_RegFile_wr_en, MEM_Exception;
   logic [1:0]  MEM_exc_cause;
   logic [31:0] MEM_ALU_result, MEM_dout;
   logic [4:0]  MEM_Rd_addr;

   int vectors = 0;
   int miscompares = 0;

   mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .EX_valid(EX_valid), .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en),
      .EX_Mem_op(EX_Mem_op), .EX_MemToReg(EX_MemToReg), .EX_RegFile_wr_en(EX_RegFile_wr_en),
      .EX_Exception(EX_Exception), .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data),
      .EX_Rd_addr(EX_Rd_addr), .MEM_stall(MEM_stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wr_data(mem_wr_data), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rd_data(mem_rd_data), .MEM_valid(MEM_valid),
      .MEM_MemToReg(MEM_MemToReg), .MEM_RegFile_wr_en(MEM_RegFile_wr_en),
      .MEM_Exception(MEM_Exception), .MEM_exc_cause(MEM_exc_cause),
      .MEM_ALU_result(MEM_ALU_result), .MEM_dout(MEM_dout), .MEM_Rd_addr(MEM_Rd_addr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                input logic [2:0] op, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [4:0] rd_addr,
                                input logic regwr, input logic m2r, input logic exc);
      EX_valid         = valid;
      EX_Mem_rd_en     = rd;
      EX_Mem_wr_en     = wr;
      EX_Mem_op        = op;
      EX_ALU_result    = alu;
      EX_Rs2_data      = rs2;
      EX_Rd_addr       = rd_addr;
      EX_RegFile_wr_en = regwr;
      EX_MemToReg      = m2r;
      EX_Exception     = exc;
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      applyStimulus(1, 1, 0, OP_W, 32'h40, 0, 5'd3, 1, 1, 0);
      mem_gnt = 1'b1;
      repeat (2) next_cycle();
      vectors++;
      if (MEM_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", MEM_valid); end
      vectors++;
      if ({MEM_RegFile_wr_en, MEM_MemToReg, MEM_Exception, MEM_exc_cause} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got %b want 00000", {MEM_RegFile_wr_en, MEM_MemToReg, MEM_Exception, MEM_exc_cause});
      end
      vectors++;
      if ({MEM_ALU_result, MEM_dout, MEM_Rd_addr} !== 69'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got %h %h %h want 0", MEM_ALU_result, MEM_dout, MEM_Rd_addr);
      end
      @(negedge Clk);
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
      next_cycle();
      Reset_n = 1'b1;
      mem_gnt = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_store_byte();
      applyStimulus(1, 0, 1, OP_B, 32'h103, 32'hAABBCCDD, 5'd0, 0, 0, 0);
      mem_gnt = 1'b1;
      @(negedge Clk);
      vectors++;
      if ({mem_req, mem_we, MEM_stall} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL sb_req_we_stall: got %b want 110", {mem_req, mem_we, MEM_stall});
      end
      vectors++;
      if (mem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL sb_addr: got %h want 00000100", mem_addr); end
      vectors++;
      if (mem_be !== 4'b1000) begin miscompares++; $display("[TB] FAIL sb_be: got %b want 1000", mem_be); end
      vectors++;
      if (mem_wr_data !== 32'hDDDDDDDD) begin miscompares++; $display("[TB] FAIL sb_wdata: got %h want DDDDDDDD", mem_wr_data); end
      next_cycle();
      mem_gnt = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (MEM_valid !== 1'b1 || MEM_ALU_result !== 32'h103) begin
         miscompares++;
         $display("[TB] FAIL sb_mem_stage: got valid=%b alu=%h want 1 00000103", MEM_valid, MEM_ALU_result);
      end
   endtask

   task automatic test_load_byte(input logic [2:0] op, input logic [31:0] expected, input string name);
      applyStimulus(1, 1, 0, op, 32'h102, 0, 5'd5, 1, 1, 0);
      mem_gnt = 1'b1;
      @(negedge Clk);
      vectors++;
      if (MEM_stall !== 1'b1 || mem_req !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s_cycle0: got stall=%b req=%b want 1 1", name, MEM_stall, mem_req);
      end
      next_cycle();
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b1;
      mem_rd_data = 32'h00800000;
      vectors++;
      if (MEM_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_bubble: got %b want 0", name, MEM_valid); end
      @(negedge Clk);
      vectors++;
      if (MEM_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_stall_end: got %b want 0", name, MEM_stall); end
      next_cycle();
      mem_rvalid = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (MEM_dout !== expected) begin miscompares++; $display("[TB] FAIL %s_dout: got %h want %h", name, MEM_dout, expected); end
      vectors++;
      if ({MEM_valid, MEM_RegFile_wr_en, MEM_Rd_addr} !== {2'b11, 5'd5}) begin
         miscompares++;
         $display("[TB] FAIL %s_wb: got %b %b %0d want 1 1 5", name, MEM_valid, MEM_RegFile_wr_en, MEM_Rd_addr);
      end
   endtask

   task automatic test_grant_delay();
      int req_cycles = 0;
      int stall_cycles = 0;
      applyStimulus(1, 1, 0, OP_H, 32'h202, 0, 5'd7, 1, 1, 0);
      mem_rd_data = 32'h80011234;
      for (int c = 0; c < 6; c++) begin
         mem_gnt    = (c == 2);
         mem_rvalid = (c == 5);
         @(negedge Clk);
         if (mem_req) req_cycles++;
         if (MEM_stall) stall_cycles++;
         next_cycle();
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (req_cycles != 3) begin miscompares++; $display("[TB] FAIL lh_req_cycles: got %0d want 3", req_cycles); end
      vectors++;
      if (stall_cycles != 5) begin miscompares++; $display("[TB] FAIL lh_stall_cycles: got %0d want 5", stall_cycles); end
      vectors++;
      if (MEM_dout !== 32'hFFFF8001 || MEM_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lh_dout: got %h valid=%b want FFFF8001 1", MEM_dout, MEM_valid);
      end
   endtask

   task automatic test_timeout();
      int  stall_cycles = 0;
      logic finished = 1'b0;
      applyStimulus(1, 1, 0, OP_W, 32'h400, 0, 5'd9, 1, 1, 0);
      mem_rd_data = 32'h55555555;
      for (int c = 0; c < 20; c++) begin
         mem_gnt    = (c == 0);
         mem_rvalid = (c == 0);
         @(negedge Clk);
         if (MEM_stall) stall_cycles++;
         else finished = 1'b1;
         next_cycle();
         if (finished) break;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (finished !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_bound: stall never ended, got %b want 1", finished); end
      vectors++;
      if (stall_cycles != 4) begin miscompares++; $display("[TB] FAIL timeout_stall_cycles: got %0d want 4", stall_cycles); end
      vectors++;
      if ({MEM_valid, MEM_Exception, MEM_exc_cause, MEM_RegFile_wr_en} !== 5'b11110) begin
         miscompares++;
         $display("[TB] FAIL timeout_exc: got %b want 11110", {MEM_valid, MEM_Exception, MEM_exc_cause, MEM_RegFile_wr_en});
      end
      vectors++;
      if (MEM_dout !== 32'hFFFF8001) begin miscompares++; $display("[TB] FAIL timeout_dout_hold: got %h want FFFF8001", MEM_dout); end
   endtask

   task automatic test_misaligned();
      applyStimulus(1, 1, 0, OP_W, 32'h301, 0, 5'd4, 1, 1, 0);
      mem_gnt = 1'b1;
      @(negedge Clk);
`ifdef MEM_MISALIGN_EXC_EN
      vectors++;
      if ({mem_req, MEM_stall} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL lw_mis_req_stall: got %b want 00", {mem_req, MEM_stall});
      end
      next_cycle();
      vectors++;
      if ({MEM_valid, MEM_Exception, MEM_exc_cause, MEM_RegFile_wr_en} !== 5'b11010) begin
         miscompares++;
         $display("[TB] FAIL lw_mis_exc: got %b want 11010", {MEM_valid, MEM_Exception, MEM_exc_cause, MEM_RegFile_wr_en});
      end
      applyStimulus(1, 0, 1, OP_W, 32'h302, 32'h12345678, 5'd0, 0, 0, 0);
      @(negedge Clk);
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_mis_req: got %b want 0", mem_req); end
      next_cycle();
      vectors++;
      if ({MEM_Exception, MEM_exc_cause} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL sw_mis_exc: got %b want 110", {MEM_Exception, MEM_exc_cause});
      end
`else
      vectors++;
      if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h300, 4'b1111}) begin
         miscompares++;
         $display("[TB] FAIL lw_unaligned_req: got req=%b addr=%h be=%b want 1 00000300 1111", mem_req, mem_addr, mem_be);
      end
      next_cycle();
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b1;
      mem_rd_data = 32'h11223344;
      next_cycle();
      mem_rvalid = 1'b0;
      vectors++;
      if ({MEM_dout, MEM_Exception, MEM_exc_cause} !== {32'h11223344, 3'b000}) begin
         miscompares++;
         $display("[TB] FAIL lw_unaligned_data: got %h exc=%b cause=%b want 11223344 0 00", MEM_dout, MEM_Exception, MEM_exc_cause);
      end
`endif
      mem_gnt = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_exception_forward();
      applyStimulus(1, 1, 0, OP_W, 32'h500, 0, 5'd2, 0, 1, 1);
      mem_gnt = 1'b1;
      @(negedge Clk);
      vectors++;
      if ({mem_req, MEM_stall} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL exc_fwd_req_stall: got %b want 00", {mem_req, MEM_stall});
      end
      next_cycle();
      mem_gnt = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({MEM_valid, MEM_Exception, MEM_exc_cause} !== 4'b1100) begin
         miscompares++;
         $display("[TB] FAIL exc_fwd_mem: got %b want 1100", {MEM_valid, MEM_Exception, MEM_exc_cause});
      end
   endtask

   task automatic test_reset_mid_transaction();
      applyStimulus(1, 1, 0, OP_W, 32'h600, 0, 5'd8, 1, 1, 0);
      mem_gnt = 1'b1;
      next_cycle();
      mem_gnt = 1'b0;
      @(negedge Clk);
      vectors++;
      if (MEM_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_in_rsp: got stall=%b want 1", MEM_stall); end
      Reset_n = 1'b0;
      next_cycle();
      vectors++;
      if ({MEM_valid, MEM_Exception, MEM_RegFile_wr_en, MEM_dout, MEM_ALU_result} !== 67'h0) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_outputs: got %b %b %b %h %h want all 0", MEM_valid, MEM_Exception, MEM_RegFile_wr_en, MEM_dout, MEM_ALU_result);
      end
      Reset_n = 1'b1;
      applyStimulus(1, 0, 0, OP_W, 32'h1234, 0, 5'd11, 1, 0, 0);
      mem_rvalid  = 1'b1;
      mem_rd_data = 32'hDEADBEEF;
      @(negedge Clk);
      vectors++;
      if ({mem_req, MEM_stall} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_alu_req_stall: got %b want 00", {mem_req, MEM_stall});
      end
      next_cycle();
      mem_rvalid = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({MEM_valid, MEM_ALU_result, MEM_dout} !== {1'b1, 32'h1234, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_alu_pass: got valid=%b alu=%h dout=%h want 1 00001234 00000000", MEM_valid, MEM_ALU_result, MEM_dout);
      end
   endtask

   initial begin
      Reset_n     = 1'b0;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rd_data = 32'h0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_store_byte();
      test_load_byte(OP_B, 32'hFFFFFF80, "lb");
      test_load_byte(OP_BU, 32'h00000080, "lbu");
      test_grant_delay();
      test_timeout();
      test_misaligned();
      test_exception_forward();
      test_reset_mid_transaction();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the MEM stage of the RV32I pipeline. It sits between EX and WB, and drives a request/grant/response data-memory port with per-byte write enables and byte-lane alignment of load/store data. It stalls the pipeline while a memory transaction is outstanding. It also detects bus timeouts and, optionally, misaligned accesses, reporting them as exceptions.

## Interface
Parameters:
- ADDR_W, 32: data-memory address width. Range 3..32; the low ADDR_W bits of EX_ALU_result are used.
- TIMEOUT_CYC, 16: maximum number of RSP cycles without mem_rvalid before a bus-timeout exception. Must be ≥1.

Ports:
- Clk  in  1  clock
- Reset_n  in  1  synchronous, active-low reset
- EX_valid  in  1  EX holds a valid instruction
- EX_Mem_wr_en / EX_Mem_rd_en  in  1  store / load request (never both)
- EX_Mem_op  in  3  funct3 encoding: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- EX_MemToReg, EX_RegFile_wr_en, EX_Exception  in  1  pipeline controls
- EX_ALU_result, EX_Rs2_data  in  32  effective address, store data
- EX_Rd_addr  in  5  destination register
- MEM_stall  out  1  hold EX/ID/IF (combinational)
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, low two bits are 0
- mem_be  out  4  byte enables
- mem_wr_data  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rd_data  in  32  read word
- MEM_valid, MEM_MemToReg, MEM_RegFile_wr_en, MEM_Exception  out  1  registered
- MEM_exc_cause  out  2  00 none/passthrough, 01 load misaligned, 10 store misaligned, 11 bus timeout
- MEM_ALU_result, MEM_dout  out  32  registered
- MEM_Rd_addr  out  5  registered

## Operation
- memop = EX_valid & (EX_Mem_rd_en | EX_Mem_wr_en) & ~EX_Exception & ~misaligned.
- Lane offset a = EX_ALU_result[1:0]. EX keeps its inputs stable while MEM_stall=1.
- FSM states:
  - IDLE: mem_req = memop. If mem_gnt, a store completes (done=1); a load goes to RSP.
  - RSP: mem_req=0. On mem_rvalid, done=1 and go to IDLE. Otherwise the timeout counter increments; when it reaches TIMEOUT_CYC, done=1, cause 11, go to IDLE.
- MEM_stall = memop & ~done.
- The counter clears on entry to RSP. Its width is $clog2(TIMEOUT_CYC+1).
- Store lanes:
  - SB: wr_data={4{rs2[7:0]}}, be=0001<<a.
  - SH: wr_data={2{rs2[15:0]}}, be=0011<<{a[1],0}.
  - SW: wr_data=rs2, be=1111.
- Load: r = mem_rd_data >> 8·a.
  - LB / LBU: sign- / zero-extend r[7:0].
  - LH / LHU: sign- / zero-extend r[15:0].
  - LW: r unmodified.
  - Loads use the lower lane of a halfword, a[0] forced to 0 unless excepting.
- MEM register update on every edge:
  - MEM_stall=0: capture EX fields, MEM_valid=EX_valid. MEM_dout is the aligned load data on load completion; otherwise it holds.
  - MEM_stall=1: bubble. MEM_valid, MEM_RegFile_wr_en, MEM_MemToReg and MEM_Exception are 0; the other fields hold.
- Exception forwarding:
  - EX_Exception=1: no request is made; MEM_Exception=1, cause 00.
  - Bus timeout: MEM_Exception=1, MEM_RegFile_wr_en=0.
- Non-memory instructions pass through with no stall.

## Timing
- Reset: state IDLE, counter 0. All MEM_* outputs are 0. mem_req is gated by Reset_n, so it is 0 during reset.
- Store with mem_gnt in the same cycle: 0 stall cycles; MEM is updated on the next edge.
- Load with gnt at cycle 0 and rvalid at cycle k≥1: MEM_stall is high for cycles 0..k-1 (k stall cycles); MEM is valid after the edge ending cycle k.
- A grant delay adds one stall cycle per cycle without mem_gnt; mem_req stays high.
- mem_rvalid is ignored in IDLE, including a simultaneous gnt+rvalid. The earliest response is the cycle after gnt.
- The memory must not respond after a timeout; a late mem_rvalid in IDLE is ignored.
- Reset mid-transaction returns the block to IDLE immediately; the outstanding response is dropped.

## Configuration
- MEM_MISALIGN_EXC_EN defined:
  - Accesses that raise a misaligned exception: LH/LHU/SH with a[0]=1, and LW/SW with a≠0.
  - No request is issued and there is no stall.
  - Next edge: MEM_Exception=1, MEM_RegFile_wr_en=0, cause 01 for a load or 10 for a store.
- Undefined:
  - misaligned is always 0. Halfword accesses force a[0]=0 and word accesses force a=00.
  - MEM_exc_cause never takes 01 or 10.

## Test plan
- SB with addr 0x103 and rs2 0xAABBCCDD, gnt in the same cycle -> mem_addr 0x100, be 1000, wr_data 0xDDDDDDDD, MEM_stall=0.
- LB with addr 0x102, gnt at cycle 0, rvalid at cycle 1 with data 0x00800000 -> exactly 1 stall cycle, MEM_dout 0xFFFFFF80. The same sequence with LBU -> MEM_dout 0x00000080.
- LH with addr 0x202, gnt delayed 2 cycles, rvalid 3 cycles after gnt, data 0x8001_1234 -> mem_req held for 3 cycles, stall for 5 cycles, MEM_dout 0xFFFF8001.
- Load with no rvalid, TIMEOUT_CYC=4 -> stall ends after 4 RSP cycles, MEM_Exception=1, cause 11, MEM_RegFile_wr_en=0.
- LW with addr 0x301, under both macro settings. With MEM_MISALIGN_EXC_EN: no mem_req, next-cycle MEM_Exception=1, cause 01. Without it: request to 0x300, be 1111, no exception.
- Reset_n=0 during RSP, followed by a late rvalid -> IDLE, all MEM_* outputs 0, the late response ignored; the next ALU op passes with MEM_valid=1.
